// File: rtl/actor_motion_ctrl.sv
// rtl/actor_motion_ctrl.sv - movement, turn buffering and mouth animation for one maze actor
//
// Purpose:
//   Turns a USB keycode into a buffered direction request. On each frame tick
//   it adopts the request when the maze allows it, steps the pixel position,
//   sequences the mouth/facing sprite index, and flags the pixels that fall
//   inside the actor's hit box.
//
// Ports:
//   Clk         system clock; frame_clk is sampled in this domain, not used as a clock
//   Reset_n     synchronous active-low reset
//   frame_clk   ~60 Hz frame strobe, asynchronous level
//   DrawX/DrawY current pixel coordinate from the VGA scan
//   keycode     USB keycode (0x04 left, 0x1A up, 0x07 right, 0x16 down)
//   open_mask   passable neighbour tiles: bit0 left, bit1 up, bit2 right, bit3 down
//   is_actor    current pixel lies inside the hit box
//   sprite_idx  sprite ROM select
//   PosX/PosY   actor position
//   Dir         0 none, 1 left, 2 up, 3 right, 4 down
//   moving      actor advanced on the last tick
//
// Build option:
//   TUNNEL_WRAP_EN  when defined, leaving past X_MIN/X_MAX wraps to the opposite
//                   edge; otherwise the actor clamps there and counts as blocked.

module actor_motion_ctrl #(
  parameter int POS_W           = 10,
  parameter int START_X         = 228,
  parameter int START_Y         = 336,
  parameter int ORG_X           = 4,
  parameter int ORG_Y           = 0,
  parameter int TILE_LOG2       = 3,
  parameter int STEP            = 1,
  parameter int SPRITE_W        = 24,
  parameter int Y_OFS           = 6,
  parameter int FRAMES_PER_STEP = 2,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 440
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_clk,
  input  logic [POS_W-1:0] DrawX,
  input  logic [POS_W-1:0] DrawY,
  input  logic [7:0]       keycode,
  input  logic [3:0]       open_mask,
  output logic             is_actor,
  output logic [3:0]       sprite_idx,
  output logic [POS_W-1:0] PosX,
  output logic [POS_W-1:0] PosY,
  output logic [2:0]       Dir,
  output logic             moving
);

  localparam int HOLD_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [POS_W-1:0]  START_X_V  = POS_W'(START_X);
  localparam logic [POS_W-1:0]  START_Y_V  = POS_W'(START_Y);
  localparam logic [POS_W-1:0]  ORG_X_V    = POS_W'(ORG_X);
  localparam logic [POS_W-1:0]  ORG_Y_V    = POS_W'(ORG_Y);
  localparam logic [POS_W-1:0]  STEP_V     = POS_W'(STEP);
  localparam logic [POS_W-1:0]  SPRITE_W_V = POS_W'(SPRITE_W);
  localparam logic [POS_W-1:0]  Y_OFS_V    = POS_W'(Y_OFS);
  localparam logic [POS_W-1:0]  X_MIN_V    = POS_W'(X_MIN);
  localparam logic [POS_W-1:0]  X_MAX_V    = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]  TILE_MASK  = POS_W'((1 << TILE_LOG2) - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(FRAMES_PER_STEP - 1);

  localparam logic [2:0] D_NONE  = 3'd0;
  localparam logic [2:0] D_LEFT  = 3'd1;
  localparam logic [2:0] D_UP    = 3'd2;
  localparam logic [2:0] D_RIGHT = 3'd3;
  localparam logic [2:0] D_DOWN  = 3'd4;

  function automatic logic dir_open(input logic [3:0] mask, input logic [2:0] d);
    case (d)
      D_LEFT:  dir_open = mask[0];
      D_UP:    dir_open = mask[1];
      D_RIGHT: dir_open = mask[2];
      D_DOWN:  dir_open = mask[3];
      default: dir_open = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] dir_rev(input logic [2:0] d);
    case (d)
      D_LEFT:  dir_rev = D_RIGHT;
      D_UP:    dir_rev = D_DOWN;
      D_RIGHT: dir_rev = D_LEFT;
      D_DOWN:  dir_rev = D_UP;
      default: dir_rev = D_NONE;
    endcase
  endfunction

  // Full-mouth frames sit at 0/1/4/5; the matching half-mouth frame is +2.
  function automatic logic [3:0] sprite_of(input logic [2:0] d, input logic [1:0] s);
    logic [3:0] full_idx;
    case (d)
      D_LEFT:  full_idx = 4'd0;
      D_UP:    full_idx = 4'd1;
      D_RIGHT: full_idx = 4'd4;
      D_DOWN:  full_idx = 4'd5;
      default: full_idx = 4'd8;
    endcase
    if (s == 2'd0 || full_idx == 4'd8) sprite_of = 4'd8;
    else if (s == 2'd2)               sprite_of = full_idx;
    else                              sprite_of = full_idx + 4'd2;
  endfunction

  // frame_clk synchroniser and rising-edge detector
  logic sync1, sync2, delay;
  logic tick;
  assign tick = sync2 & ~delay;

  logic [2:0]        pending;
  logic [1:0]        step;
  logic [HOLD_W-1:0] hold;

  logic [2:0] key_dir;
  always_comb begin
    key_dir = D_NONE;
    case (keycode)
      8'h04:   key_dir = D_LEFT;
      8'h1A:   key_dir = D_UP;
      8'h07:   key_dir = D_RIGHT;
      8'h16:   key_dir = D_DOWN;
      default: key_dir = D_NONE;
    endcase
  end

  logic             aligned;
  logic             turn;
  logic [2:0]       nxt_dir;
  logic [POS_W-1:0] nxt_x, nxt_y;
  logic             nxt_mov;
  logic [1:0]       nxt_step;
  logic [HOLD_W-1:0] nxt_hold;

  always_comb begin
    aligned  = (((PosX - ORG_X_V) & TILE_MASK) == '0) &&
               (((PosY - ORG_Y_V) & TILE_MASK) == '0);
    turn     = (pending != D_NONE) && (pending != Dir) &&
               ((pending == dir_rev(Dir)) || (aligned && dir_open(open_mask, pending)));
    nxt_dir  = turn ? pending : Dir;
    nxt_x    = PosX;
    nxt_y    = PosY;
    nxt_mov  = 1'b0;

    if (nxt_dir != D_NONE && (!aligned || dir_open(open_mask, nxt_dir))) begin
      nxt_mov = 1'b1;
      case (nxt_dir)
        D_LEFT: begin
          if (PosX < X_MIN_V + STEP_V) begin
`ifdef TUNNEL_WRAP_EN
            nxt_x = X_MAX_V;
`else
            nxt_x   = X_MIN_V;
            nxt_mov = (PosX != X_MIN_V);
`endif
          end else begin
            nxt_x = PosX - STEP_V;
          end
        end
        D_RIGHT: begin
          if (PosX > X_MAX_V - STEP_V) begin
`ifdef TUNNEL_WRAP_EN
            nxt_x = X_MIN_V;
`else
            nxt_x   = X_MAX_V;
            nxt_mov = (PosX != X_MAX_V);
`endif
          end else begin
            nxt_x = PosX + STEP_V;
          end
        end
        D_UP:    nxt_y = PosY - STEP_V;
        default: nxt_y = PosY + STEP_V;
      endcase
    end

    // A turn restarts the mouth at half-open; otherwise the mouth only
    // advances while the actor is actually moving.
    nxt_step = step;
    nxt_hold = hold;
    if (turn) begin
      nxt_step = 2'd1;
      nxt_hold = '0;
    end else if (nxt_mov) begin
      if (hold == HOLD_LAST) begin
        nxt_step = step + 2'd1;
        nxt_hold = '0;
      end else begin
        nxt_hold = hold + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      delay      <= 1'b0;
      pending    <= D_NONE;
      Dir        <= D_NONE;
      PosX       <= START_X_V;
      PosY       <= START_Y_V;
      moving     <= 1'b0;
      step       <= 2'd0;
      hold       <= '0;
      sprite_idx <= 4'd8;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      delay <= sync2;

      // A fresh key overrides the clear so a press on the adopting tick survives.
      if (key_dir != D_NONE)  pending <= key_dir;
      else if (tick && turn)  pending <= D_NONE;

      if (tick) begin
        Dir        <= nxt_dir;
        PosX       <= nxt_x;
        PosY       <= nxt_y;
        moving     <= nxt_mov;
        step       <= nxt_step;
        hold       <= nxt_hold;
        sprite_idx <= sprite_of(nxt_dir, nxt_step);
      end
    end
  end

  // Unsigned differences: pixels left of or above the box wrap to large values.
  logic [POS_W-1:0] dx, dy;
  always_comb begin
    dx       = DrawX - PosX;
    dy       = DrawY - PosY - Y_OFS_V;
    is_actor = (dx < SPRITE_W_V) && (dy < SPRITE_W_V);
  end

endmodule

// File: tb/tb_actor_motion_ctrl.sv
// tb/tb_actor_motion_ctrl.sv - directed-vector bench for actor_motion_ctrl

module tb_actor_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic [9:0] DrawX, DrawY;
  logic [7:0] keycode;
  logic [3:0] open_mask;
  logic       is_actor;
  logic [3:0] sprite_idx;
  logic [9:0] PosX, PosY;
  logic [2:0] Dir;
  logic       moving;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  actor_motion_ctrl dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .keycode    (keycode),
    .open_mask  (open_mask),
    .is_actor   (is_actor),
    .sprite_idx (sprite_idx),
    .PosX       (PosX),
    .PosY       (PosY),
    .Dir        (Dir),
    .moving     (moving)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset_n = 1'b0;
    @(negedge Clk) Reset_n = 1'b1;
  endtask

  task automatic frame_tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic press(input logic [7:0] k);
    @(negedge Clk) keycode = k;
    @(negedge Clk) keycode = 8'h00;
  endtask

  task automatic probe(input int x, input int y, input int exp, input string tag);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1 check(tag, int'(is_actor), exp);
  endtask

  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    keycode   = 8'h00;
    open_mask = 4'hF;
    DrawX     = '0;
    DrawY     = '0;
    do_reset();

    // Reset state and hit box edges
    check("rst_posx", int'(PosX), 228);
    check("rst_posy", int'(PosY), 336);
    check("rst_dir", int'(Dir), 0);
    check("rst_sprite", int'(sprite_idx), 8);
    check("rst_moving", int'(moving), 0);
    probe(228, 342, 1, "hit_topleft");
    probe(228, 341, 0, "hit_above");
    probe(252, 342, 0, "hit_right_edge");
    probe(251, 365, 1, "hit_bottomright");

    // Start moving left from rest
    press(8'h04);
    frame_tick();
    check("left1_dir", int'(Dir), 1);
    check("left1_posx", int'(PosX), 227);
    check("left1_sprite", int'(sprite_idx), 2);
    check("left1_moving", int'(moving), 1);
    frame_tick();
    check("left2_posx", int'(PosX), 226);
    check("left2_sprite", int'(sprite_idx), 2);
    frame_tick();
    check("left3_posx", int'(PosX), 225);
    check("left3_sprite", int'(sprite_idx), 0);

    // Down request buffered until the next tile boundary
    press(8'h16);
    repeat (5) frame_tick();
    check("buf_dir_hold", int'(Dir), 1);
    check("buf_posx", int'(PosX), 220);
    frame_tick();
    check("buf_dir_turn", int'(Dir), 4);
    check("buf_posy", int'(PosY), 337);
    check("buf_posx_keep", int'(PosX), 220);
    check("buf_sprite", int'(sprite_idx), 7);

    // Reset while moving, then reverse mid-tile
    do_reset();
    check("rst2_posy", int'(PosY), 336);
    check("rst2_dir", int'(Dir), 0);
    check("rst2_sprite", int'(sprite_idx), 8);
    press(8'h04);
    repeat (5) frame_tick();
    check("rev_pre_posx", int'(PosX), 223);
    check("rev_pre_sprite", int'(sprite_idx), 2);
    press(8'h07);
    frame_tick();
    check("rev_dir", int'(Dir), 3);
    check("rev_posx", int'(PosX), 224);
    check("rev_sprite", int'(sprite_idx), 6);

    // Blocked by a wall: position and animation freeze
    do_reset();
    press(8'h04);
    repeat (8) frame_tick();
    check("blk_pre_posx", int'(PosX), 220);
    check("blk_pre_sprite", int'(sprite_idx), 8);
    open_mask = 4'b1110;
    repeat (5) frame_tick();
    check("blk_posx", int'(PosX), 220);
    check("blk_moving", int'(moving), 0);
    check("blk_dir", int'(Dir), 1);
    check("blk_sprite", int'(sprite_idx), 8);
    open_mask = 4'hF;
    frame_tick();
    check("unblk_posx", int'(PosX), 219);
    check("unblk_sprite", int'(sprite_idx), 2);

    // Left edge: clamp by default, wrap when the tunnel option is built in
    repeat (219) frame_tick();
    check("edge_posx", int'(PosX), 0);
    check("edge_moving", int'(moving), 1);
    probe(0, 342, 1, "edge_hit");
    frame_tick();
`ifdef TUNNEL_WRAP_EN
    check("wrap_posx", int'(PosX), 440);
    check("wrap_moving", int'(moving), 1);
`else
    check("clamp_posx", int'(PosX), 0);
    check("clamp_moving", int'(moving), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/actor_motion_ctrl.md
Name: actor_motion_ctrl

Overview:
- Parametrised movement and animation controller for one maze actor (Pac-Man or a ghost).
- Converts a keycode into a buffered turn request, gated by the maze wall mask.
- Steps the actor's pixel position once per frame tick and sequences the mouth/facing sprite index.
- Generates the per-pixel hit flag for the VGA compositor.
- Runs entirely in the Clk domain; frame_clk is edge-detected, not used as a clock.

Parameters:
- POS_W, 10, width of DrawX/DrawY/PosX/PosY.
- START_X, 228, reset X position.
- START_Y, 336, reset Y position.
- ORG_X, 4, X grid origin for tile alignment.
- ORG_Y, 0, Y grid origin for tile alignment.
- TILE_LOG2, 3, log2 of tile size in pixels (8).
- STEP, 1, pixels moved per tick; power of 2, ≤ 2^TILE_LOG2.
- SPRITE_W, 24, hit-box width and height.
- Y_OFS, 6, vertical draw offset of the hit box.
- FRAMES_PER_STEP, 2, ticks each mouth step is held.
- X_MIN, 0, left clamp/wrap limit.
- X_MAX, 440, right clamp/wrap limit.

Ports:
- Clk, in, 1, 50 MHz system clock.
- Reset_n, in, 1, synchronous active-low reset.
- frame_clk, in, 1, ~60 Hz frame strobe (asynchronous level).
- DrawX, in, POS_W, current pixel X.
- DrawY, in, POS_W, current pixel Y.
- keycode, in, 8, USB keycode.
- open_mask, in, 4, passable neighbour tiles of the current tile: bit0 left, bit1 up, bit2 right, bit3 down.
- is_actor, out, 1, current pixel is inside the hit box.
- sprite_idx, out, 4, sprite ROM select.
- PosX, out, POS_W, actor X.
- PosY, out, POS_W, actor Y.
- Dir, out, 3, current direction: 0 none, 1 left, 2 up, 3 right, 4 down.
- moving, out, 1, actor advanced on the last tick.

Behaviour:
- Reset (Reset_n=0 at a Clk edge) has priority over everything, including mid-move.
  - PosX=START_X, PosY=START_Y.
  - Dir=0, pending=0, moving=0.
  - Phase counters = 0, sprite_idx=8, edge-detect flops = 0.
- Tick generation:
  - frame_clk passes through 2 sync flops plus 1 delay flop.
  - tick = sync & ~delay; a one-Clk pulse 3 Clk after the frame_clk rise.
  - All state below changes only on tick cycles, except pending.
- Key decode: 0x04→1, 0x1A→2, 0x07→3, 0x16→4; any other code = no request.
  - A nonzero decode loads pending on any Clk.
  - pending holds until adopted.
  - On a tick cycle, the tick logic uses the pending value registered before that cycle.
- Alignment: aligned = (PosX-ORG_X)[TILE_LOG2-1:0]==0 and (PosY-ORG_Y)[TILE_LOG2-1:0]==0.
- Each tick, in order:
  1. Turn: if pending≠0 and pending≠Dir, adopt it (Dir=pending, pending=0) when either:
     - pending is the reverse of Dir (adopt anytime); or
     - aligned and open_mask[pending-1]=1.
     - Otherwise keep pending.
     - A turn sets mouth step = half (step 1) and clears the hold counter.
  2. Move: if Dir≠0 and (not aligned or open_mask[Dir-1]=1), add ±STEP on the axis and set moving=1. Otherwise set moving=0 (blocked; Dir retained).
  3. X limits: left of X_MIN clamps to X_MIN; right of X_MAX clamps to X_MAX. Y has no clamp; the maze guarantees walls.
- Animation: 4-step mouth cycle closed(0) → half(1) → full(2) → half(3) → closed.
  - Each step is held FRAMES_PER_STEP ticks.
  - Advances only on ticks with moving=1; frozen when blocked.
- sprite_idx, registered, updated on the tick cycle:
  - Dir=0 or step 0 → 8.
  - Full mouth: left 0, up 1, right 4, down 5.
  - Half mouth: left 2, up 3, right 6, down 7.
- is_actor (combinational): (DrawX-PosX) < SPRITE_W and (DrawY-PosY-Y_OFS) < SPRITE_W.
  - Unsigned POS_W-bit subtraction, so negative differences fail the compare.
- Simultaneous key and tick: the tick sees the old pending; the new key is applied from the next tick.

Optional Feature:
- Macro TUNNEL_WRAP_EN.
- Defined:
  - Moving left with PosX=X_MIN sets PosX=X_MAX.
  - Moving right with PosX=X_MAX sets PosX=X_MIN.
  - moving=1 and the animation advances on the wrap tick.
- Undefined: clamp as above. At a clamp the tick counts as blocked (moving=0).

Test Plan:
- Reset: Reset_n=0 one Clk → PosX=228, PosY=336, Dir=0, sprite_idx=8. DrawX=228,DrawY=342 → is_actor=1; DrawY=341 → 0; DrawX=252 → 0.
- Start left: keycode 0x04, open_mask=4'hF, 3 ticks → Dir=1; PosX 227, 226, 225; sprite_idx 2, 2, 0.
- Buffered turn: moving left at PosX=225, press 0x16 → Dir stays 1 until PosX=220 (aligned); next tick Dir=4, PosY=337, PosX=220.
- Blocked: Dir=1 at aligned PosX=220, open_mask=4'b1110 → PosX holds 220, moving=0, sprite_idx unchanged over 5 ticks.
- Reverse: moving left at PosX=223, press 0x07 → next tick Dir=3, PosX=224, sprite_idx=6.
- Wrap (TUNNEL_WRAP_EN): PosX=0, Dir=1, tick → PosX=440. Without the macro → PosX=0, moving=0.
